fpu_add_arbiter: RTL

Shares one FP adder (start / a-b strobe-ack / z strobe-ack / output_valid protocol) among NUM_REQ requesters. It picks a requester by round-robin, sequences the full adder handshake, and returns the 32-bit result tagged with the requester id. A watchdog aborts hung operations and re-initialises the adder through its active-high synchronous reset.

---
 rtl/fpu_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fpu_add_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FP adder arbiter: FSM encoding, abort result
// value and the requester-id width helper.
package fpu_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_WAIT_Z = 3'd4,
    S_DRAIN  = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  // Quiet NaN handed back when an operation is aborted by the watchdog.
  localparam logic [31:0] ERR_VALUE_DEF = 32'h7FC0_0000;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request found scanning
// from ptr upward (modulo NUM_REQ) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = |req;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one handshaked FP adder among NUM_REQ requesters. Requests are
// granted round-robin; the full start / operand / result handshake is
// sequenced by a small FSM, and a watchdog aborts operations that hang,
// resetting the adder and returning ERR_VALUE with resp_err set.
//
// Handshake rules: a requester holds req_valid with stable operands until
// it sees its one-cycle req_ready pulse. Toward the adder, add_a_stb and
// add_b_stb rise and stay high with stable data until the edge on which the
// matching ack is seen high; add_ack_output is high while a result is
// awaited and until add_output_valid is seen. resp_valid is a one-cycle
// pulse; resp_id, resp_z and resp_err hold their values between pulses.
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          ID_W      = id_width(NUM_REQ),
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_VALUE = ERR_VALUE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_z,
  output logic                  resp_err,
  output logic                  add_start,
  output logic                  add_rst,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_a_stb,
  output logic                  add_b_stb,
  input  logic                  add_a_ack,
  input  logic                  add_b_ack,
  input  logic [31:0]           add_z,
  input  logic                  add_z_stb,
  output logic                  add_ack_output,
  input  logic                  add_idle,
  input  logic                  add_output_valid,
  output logic [2:0]            dbg_state
);

  localparam int              TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      cur_id;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [31:0]          z_cap;
  logic                 timed;
  logic                 abort;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .id   (arb_id),
    .any  (arb_any)
  );

  // The watchdog only runs while the adder owes us a handshake.
  assign timed = (state == S_SEND_A) || (state == S_SEND_B) ||
                 (state == S_WAIT_Z) || (state == S_DRAIN);
  assign abort = timed && (timer == TIMER_W'(TIMEOUT));

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a watchdog abort overrides any pending handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (add_idle && arb_any) state_nxt = S_START;
      S_START:  state_nxt = S_SEND_A;
      S_SEND_A: if (abort) state_nxt = S_RESP;
                else if (add_a_ack) state_nxt = S_SEND_B;
      S_SEND_B: if (abort) state_nxt = S_RESP;
                else if (add_b_ack) state_nxt = S_WAIT_Z;
      S_WAIT_Z: if (abort) state_nxt = S_RESP;
                else if (add_z_stb) state_nxt = S_DRAIN;
      S_DRAIN:  if (abort) state_nxt = S_RESP;
                else if (add_output_valid) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state flops.
  always_comb begin
    req_ready      = (state == S_START) ? gnt_r : '0;
    add_start      = (state == S_START);
    add_a_stb      = (state == S_SEND_A);
    add_b_stb      = (state == S_SEND_B);
    add_ack_output = (state == S_WAIT_Z) || (state == S_DRAIN);
    resp_valid     = (state == S_RESP);
  end

  // Grant capture, watchdog timer, result capture and adder reset pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_rst <= 1'b1;
      cur_id  <= '0;
      gnt_r   <= '0;
      add_a   <= '0;
      add_b   <= '0;
      timer   <= '0;
      z_cap   <= '0;
    end else begin
      add_rst <= abort;
      case (state)
        S_IDLE: begin
          if (add_idle && arb_any) begin
            cur_id <= arb_id;
            gnt_r  <= arb_grant;
            add_a  <= req_a[32*int'(arb_id) +: 32];
            add_b  <= req_b[32*int'(arb_id) +: 32];
          end
        end
        S_START:  timer <= '0;
        S_SEND_A, S_SEND_B, S_DRAIN: timer <= timer + 1'b1;
        S_WAIT_Z: begin
          timer <= timer + 1'b1;
          if (add_z_stb) z_cap <= add_z;
        end
        default: ;
      endcase
    end
  end

  // Response registers, loaded on the edge into S_RESP and held afterwards;
  // the round-robin pointer moves past the requester just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_z   <= '0;
      resp_id  <= '0;
      resp_err <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (abort) begin
        resp_z   <= ERR_VALUE;
        resp_err <= 1'b1;
        resp_id  <= cur_id;
      end else if ((state == S_DRAIN) && add_output_valid) begin
        resp_z   <= z_cap;
        resp_err <= 1'b0;
        resp_id  <= cur_id;
      end
      if (state == S_RESP) rr_ptr <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
    end
  end

endmodule
